// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : counter_seq_ctrl
// Description : Sequencer for an external WIDTH-bit up-counter datapath.
//               Issues a one-cycle clear, then prescaled increment strobes
//               until the counter reaches the programmed terminal count,
//               pulses done, and either stops (one-shot) or restarts
//               (auto-reload).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   ena         in   low freezes all state and silences the strobes
//   start       in   level, begins a sequence from IDLE
//   stop        in   level, aborts any sequence (beats start)
//   auto_reload in   latched at start: restart after done
//   prescale    in   latched at start: count every prescale+1 RUN cycles
//   terminal    in   latched at start: count value that ends the sequence
//   cnt_value   in   registered count from the datapath
//   cnt_clr     out  clear strobe to the counter
//   cnt_en      out  increment strobe to the counter
//   done        out  one-cycle pulse on terminal match
//   busy        out  high whenever the FSM is not IDLE
//   state       out  FSM state for debug (IDLE=0 CLEAR=1 RUN=2 WAIT=3)
//   irq         out  sticky completion flag (COUNTER_SEQ_IRQ_STICKY_EN only)
//   irq_clr     in   clears irq (COUNTER_SEQ_IRQ_STICKY_EN only)
// Optional feature macro: COUNTER_SEQ_IRQ_STICKY_EN
// ============================================================================
module counter_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int PS_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    input  logic [PS_W-1:0]  prescale,
    input  logic [WIDTH-1:0] terminal,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             cnt_clr,
    output logic             cnt_en,
    output logic             done,
    output logic             busy,
    output logic [1:0]       state,
    output logic             irq,
    input  logic             irq_clr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_CLEAR = 2'b01,
        S_RUN   = 2'b10,
        S_WAIT  = 2'b11
    } state_t;

    localparam logic [PS_W-1:0] c_ps_one = {{(PS_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PS_W-1:0]   r_ps_cnt;
    logic [PS_W-1:0]   w_ps_cnt_nxt;
    logic [PS_W-1:0]   r_ps_shd;
    logic [WIDTH-1:0]  r_term_shd;
    logic              r_auto_shd;
    logic              w_latch;
    logic              w_match;
    logic              w_clr;
    logic              w_en;
    logic              w_done;

    // cnt_value already reflects the strobe of the previous cycle, so the
    // match is seen on the first cycle the counter sits at terminal.
    assign w_match = (cnt_value == r_term_shd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ps_cnt   <= '0;
            r_ps_shd   <= '0;
            r_term_shd <= '0;
            r_auto_shd <= 1'b0;
        end else if (ena) begin
            r_state  <= w_state_nxt;
            r_ps_cnt <= w_ps_cnt_nxt;
            if (w_latch) begin
                r_ps_shd   <= prescale;
                r_term_shd <= terminal;
                r_auto_shd <= auto_reload;
            end
        end
    end

    // Everything below is qualified by ena: with ena low the strobes stay
    // quiet and the registers above hold, so operation resumes seamlessly.
    always_comb begin
        w_state_nxt  = r_state;
        w_ps_cnt_nxt = r_ps_cnt;
        w_latch      = 1'b0;
        w_clr        = 1'b0;
        w_en         = 1'b0;
        w_done       = 1'b0;
        if (ena) begin
            if (stop) begin
                w_state_nxt  = S_IDLE;
                w_ps_cnt_nxt = '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            w_latch     = 1'b1;
                            w_state_nxt = S_CLEAR;
                        end
                    end
                    S_CLEAR: begin
                        w_clr        = 1'b1;
                        w_ps_cnt_nxt = '0;
                        w_state_nxt  = S_RUN;
                    end
                    S_RUN: begin
                        if (w_match) begin
                            w_done      = 1'b1;
                            w_state_nxt = r_auto_shd ? S_CLEAR : S_WAIT;
                        end else if (r_ps_cnt == r_ps_shd) begin
                            w_en         = 1'b1;
                            w_ps_cnt_nxt = '0;
                        end else begin
                            w_ps_cnt_nxt = r_ps_cnt + c_ps_one;
                        end
                    end
                    S_WAIT: begin
                        // Wait for start to drop so a held start cannot
                        // immediately launch another one-shot.
                        if (!start) begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                    default: begin
                        w_state_nxt = S_IDLE;
                    end
                endcase
            end
        end
    end

    assign cnt_clr = w_clr;
    assign cnt_en  = w_en;
    assign done    = w_done;
    assign busy    = (r_state != S_IDLE);
    assign state   = r_state;

`ifdef COUNTER_SEQ_IRQ_STICKY_EN
    logic r_irq;

    // Set beats clear so a completion coinciding with irq_clr is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else if (ena) begin
            if (w_done) begin
                r_irq <= 1'b1;
            end else if (irq_clr) begin
                r_irq <= 1'b0;
            end
        end
    end

    assign irq = r_irq;
`else
    logic w_unused_irq_clr;

    assign w_unused_irq_clr = irq_clr;
    assign irq              = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Sequencer for the team's 8-bit up-counter datapath.
- Drives the counter's clear and count-enable strobes and watches its count value against a programmed terminal count.
- Generates a prescaled count rate, signals completion, and supports one-shot or auto-reload operation.
- Sits between the Tiny Tapeout top-level pins (ena, ui_in-derived controls) and the counter register.

Parameters:
- WIDTH, 8, width of the counter value and the terminal count.
- PS_W, 4, width of the prescaler divide setting.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- ena  input  1  design-selected enable; low freezes all state.
- start  input  1  level; begins a sequence when sampled high in IDLE.
- stop  input  1  level; aborts any sequence; has priority over start.
- auto_reload  input  1  sampled at start; 1 = restart after done, 0 = one-shot.
- prescale  input  PS_W  sampled at start; count once every prescale+1 cycles.
- terminal  input  WIDTH  sampled at start; count value that ends the sequence.
- cnt_value  input  WIDTH  registered output of the counter datapath.
- cnt_clr  output  1  synchronous clear strobe to the counter.
- cnt_en  output  1  increment strobe to the counter.
- done  output  1  one-cycle pulse on terminal match.
- busy  output  1  high in any state other than IDLE.
- state  output  2  current FSM state encoding, for debug.
- irq  output  1  sticky completion flag (optional feature only, else 0).
- irq_clr  input  1  clears irq (optional feature only, else ignored).

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE; prescaler counter, shadow registers and irq go to 0.
  - All outputs are 0 (state = 2'b00).
- States: IDLE=0, CLEAR=1, RUN=2, WAIT=3.
- IDLE:
  - start=1 & stop=0 → CLEAR.
  - At that transition, latch terminal, prescale and auto_reload into shadow registers.
  - Input changes after the latch have no effect until the next start.
- CLEAR:
  - cnt_clr=1 for exactly one cycle; prescaler counter ← 0.
  - Next state is RUN.
- RUN:
  - match = (cnt_value == shadow terminal).
  - If match: done=1 this cycle and cnt_en=0. Next state is CLEAR if shadow auto_reload=1, else WAIT.
  - If no match:
    - The prescaler counter increments each cycle.
    - When it equals shadow prescale, cnt_en=1 for that cycle and the prescaler counter ← 0.
    - prescale=0 gives cnt_en on every RUN cycle.
- WAIT:
  - Holds until start=0, then → IDLE.
  - Prevents a held start from retriggering.
- Output decode:
  - cnt_clr, cnt_en and done are combinational from registered state, the prescaler counter and cnt_value.
  - All three are gated by ena.
- busy = (state != IDLE); it is not gated by ena.
- stop=1 in any state:
  - Next state is IDLE; prescaler counter ← 0.
  - cnt_en and done are forced 0 that cycle.
  - stop and start both high in IDLE: remain in IDLE.
- ena=0:
  - No state, prescaler or shadow register updates; start and stop are ignored.
  - cnt_clr, cnt_en and done are 0.
  - Operation resumes exactly where it left off when ena returns to 1.
- terminal=0: the first RUN cycle after CLEAR matches (counter reads 0) → done with no cnt_en pulses.
- Counter wrap: the controller never lets the counter pass terminal. A terminal value above the counter's reach is not possible, since the widths are equal.
- Counter latency: the datapath updates cnt_value one cycle after cnt_en/cnt_clr. The match check uses the post-update value, so the count never exceeds terminal.
- Auto-reload period: (terminal × (prescale+1)) + 2 cycles per sequence, covering the CLEAR cycle and the match cycle.

Optional Feature:
- Macro: COUNTER_SEQ_IRQ_STICKY_EN.
- Defined:
  - irq is a register set on any cycle with done=1 and cleared on irq_clr=1.
  - Set wins when both occur in the same cycle.
  - irq holds during ena=0 and resets to 0.
- Undefined: irq is tied to 0, irq_clr is unconnected internally, and no extra flops are inferred.

Test Plan:
- Reset, then start=1 with terminal=5, prescale=0, auto_reload=0:
  - cnt_clr pulses 1 cycle, then 5 consecutive cnt_en pulses.
  - done pulses when cnt_value=5.
  - state → WAIT, then IDLE after start drops; busy low in IDLE.
- terminal=3, prescale=2: cnt_en fires every 3rd RUN cycle, 3 pulses total; done on the 10th cycle after the CLEAR cycle.
- auto_reload=1, terminal=4, prescale=0:
  - done repeats every 6 cycles, with cnt_clr one cycle after each done.
  - stop=1 mid-run → IDLE next cycle with no further strobes.
- ena dropped for 7 cycles mid-RUN (terminal=8, prescale=1): no strobes while low; total cnt_en count stays 8 and done is delayed by exactly 7 cycles.
- terminal=0 start: cnt_clr, then done on the next cycle, zero cnt_en pulses. Also: rst_n asserted mid-RUN → all outputs 0 immediately, without waiting for a clock edge.
- With COUNTER_SEQ_IRQ_STICKY_EN: irq rises with done and stays high; irq_clr=1 clears it; done and irq_clr in the same cycle leaves irq=1.
